// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO with standard or first-word-fall-through read mode, programmable
// almost-full/almost-empty thresholds, exposed fill level and sticky overflow/underflow flags.
module fifo_sync_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AFULL_TH  = DEPTH - 4,
    parameter int unsigned AEMPTY_TH = 4
) (
    input  logic                       i_clk,
    input  logic                       srst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_almost_full,
    output logic                       o_almost_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic                       o_underflow,
    input  logic                       clr_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] AfullTh  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AemptyTh = CW'(AEMPTY_TH);
    localparam logic [CW-1:0] DepthC   = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_acc, rd_acc;

    always_comb begin
        // Acceptance is decided from the registered flags only; no pass-through at full/empty.
        wr_acc   = wr_en && !full_q;
        rd_acc   = rd_en && !empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + CW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + CW'(1) : rd_ptr_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d     = (count_d == DepthC);
        empty_d    = (count_d == '0);
        afull_d    = (count_d >= AfullTh);
        aempty_d   = (count_d <= AemptyTh);
        ovf_d      = (wr_en && full_q) || (ovf_q && !clr_err);
        udf_d      = (rd_en && empty_q) || (udf_q && !clr_err);
        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? mem_q[rd_ptr_q[AW-1:0]] : rd_data_q;
    end

    always_ff @(posedge i_clk) begin
        if (srst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is never cleared; reset only blocks a write issued in the same cycle.
    always_ff @(posedge i_clk) begin
        if (wr_acc && !srst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data  = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        assign rd_valid = !empty_q;
    end else begin : g_std
        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = afull_q;
    assign o_almost_empty = aempty_q;
    assign o_count        = count_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
Parametrised single-clock FIFO that succeeds the basic WIDTH/DEPTH FIFO. It adds a selectable read mode (registered standard read or first-word-fall-through), programmable almost-full/almost-empty thresholds, an exposed fill level, and sticky overflow/underflow error flags with a clear input. It sits between producer and consumer datapaths in the same clock domain and is the drop-in buffer for new blocks needing flow-control headroom.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 128, number of entries; power of two, >=4
FWFT, 0, read mode: 0 = standard (rd_data registered, 1-cycle latency), 1 = first-word-fall-through
AFULL_TH, DEPTH-4, o_almost_full asserted when count >= AFULL_TH; legal range 1..DEPTH
AEMPTY_TH, 4, o_almost_empty asserted when count <= AEMPTY_TH; legal range 0..DEPTH-1

Ports:
i_clk  in  1  clock, all logic on rising edge
srst  in  1  synchronous active-high reset
wr_en  in  1  write request
wr_data  in  WIDTH  write data
rd_en  in  1  read request (pop)
rd_data  out  WIDTH  read data
rd_valid  out  1  rd_data valid qualifier
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_almost_full  out  1  count >= AFULL_TH
o_almost_empty  out  1  count <= AEMPTY_TH
o_count  out  $clog2(DEPTH)+1  current fill level, 0..DEPTH
o_overflow  out  1  sticky: write attempted while full
o_underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of o_overflow/o_underflow

Behaviour:
- Reset (srst=1 at a rising edge): wr_ptr, rd_ptr, count = 0; o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0, rd_data=0, rd_valid=0, o_overflow=0, o_underflow=0. Memory contents are not cleared. srst takes priority over every other input in the same cycle; an in-flight standard-mode read is dropped (rd_valid=0 the next cycle).
- Pointers are $clog2(DEPTH)+1 bits; the low bits index memory and the MSB is the wrap bit. Both pointers wrap modulo 2*DEPTH with no gap.
- Write accepted iff wr_en && !o_full: mem[wr_ptr] <= wr_data, wr_ptr+1.
- Read accepted iff rd_en && !o_empty: rd_ptr+1.
- Acceptance uses the pre-edge flags. There is no pass-through: a write while full is rejected even if a read is accepted in the same cycle, and a read while empty is rejected even if a write is accepted in the same cycle.
- count: +1 on write only, -1 on read only, unchanged on both or neither. All flags and o_count are registered and update on the same edge as count.
- Error flags:
  - wr_en && o_full sets o_overflow.
  - rd_en && o_empty sets o_underflow.
  - Both stay set until clr_err or srst. If set and clear occur in the same cycle, set wins.
  - Rejected operations do not change data, pointers, or count.
- FWFT=0: on an accepted read, rd_data <= mem[rd_ptr] and rd_valid=1 on the next cycle. rd_valid is a single-cycle pulse per accepted read. rd_data holds its last value otherwise.
- FWFT=1: rd_data = mem[rd_ptr] continuously and rd_valid = !o_empty. An accepted read advances to the next word, which is visible after the edge. The first write into an empty FIFO appears on rd_data with rd_valid=1 one cycle after the write edge.
- Back-to-back reads and writes every cycle sustain full throughput, 1 word per cycle each direction.

Test Plan:
- Reset/idle (DEPTH=8, AFULL_TH=6, AEMPTY_TH=1): hold srst 2 cycles -> o_empty=1, o_almost_empty=1, o_count=0, rd_valid=0, error flags 0.
- Fill then drain, FWFT=0: write 8 words 0xA0..0xA7 -> o_almost_full at o_count=6, o_full at 8. Ninth write of 0xFF -> o_overflow=1, o_count stays 8. Read 8 -> rd_data 0xA0..0xA7 each one cycle after rd_en with rd_valid pulses. Extra read -> o_underflow=1. clr_err -> both flags 0.
- FWFT=1: write 0x11 into empty -> next cycle rd_data=0x11, rd_valid=1 with no rd_en. Write 0x22, pulse rd_en -> rd_data=0x22. Pulse rd_en again -> o_empty=1, rd_valid=0.
- Simultaneous ops:
  - At count=4, wr_en and rd_en together for 20 cycles -> o_count stays 4 and data order is preserved across pointer wrap.
  - At full, wr_en+rd_en -> read accepted, write rejected, o_overflow=1, o_count=7.
  - At empty, wr_en+rd_en -> o_underflow=1, o_count=1.
- Reset mid-operation: with o_count=5 and a standard-mode read in flight, assert srst -> next cycle o_count=0, o_empty=1, rd_valid=0. Subsequent write/read of 0x5A returns 0x5A.
- Random scoreboard: 2000 cycles of random wr_en/rd_en (25% each) in both FWFT modes against a reference queue -> zero data mismatches; o_count always equals queue size; flags consistent with thresholds.
